// File: rtl/bayer_pkg.sv
// Shared types for the 3x3 Bayer demosaic block: CFA order, site colour, pipeline latency.
package bayer_pkg;

    typedef enum logic [1:0] {
        PAT_RGGB = 2'd0,
        PAT_BGGR = 2'd1,
        PAT_GRBG = 2'd2,
        PAT_GBRG = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_e;

    localparam int LATENCY = 4;

    // Every CFA order is RGGB with the column and/or row parity flipped.
    function automatic site_e site_decode(pattern_e pat, logic col_odd, logic row_odd);
        logic h;
        logic v;
        h = col_odd ^ ((pat == PAT_BGGR) || (pat == PAT_GRBG));
        v = row_odd ^ ((pat == PAT_BGGR) || (pat == PAT_GBRG));
        return site_e'({v, h});
    endfunction

endpackage

// File: rtl/bayer_window3x3.sv
// 3x3 sliding window over three parallel rows with horizontal edge replication
// and the centre-column parity for site decoding.
module bayer_window3x3 #(
    parameter int DATA_WIDTH = 10,
    parameter int LINE_WIDTH = 11
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               de,
    input  logic [DATA_WIDTH-1:0]              data0,
    input  logic [DATA_WIDTH-1:0]              data1,
    input  logic [DATA_WIDTH-1:0]              data2,
    output logic [2:0][2:0][DATA_WIDTH-1:0]    win,
    output logic                               valid,
    output logic                               col_odd
);

    logic                  de_prev_reg;
    logic                  de_d2_reg;
    logic [LINE_WIDTH-1:0] hcount_reg;
    logic                  line_start;
    logic                  line_end;
    logic [2:0][DATA_WIDTH-1:0] row_data;

    assign row_data   = {data2, data1, data0};
    assign line_start = de & ~de_prev_reg;
    assign line_end   = ~de & de_prev_reg;

    // Centre column is two cycles behind the input; hcount tracks that column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_prev_reg <= 1'b0;
            de_d2_reg   <= 1'b0;
            hcount_reg  <= '0;
        end else begin
            de_prev_reg <= de;
            de_d2_reg   <= de_prev_reg;
            if (de_prev_reg) begin
                hcount_reg <= de_d2_reg ? hcount_reg + LINE_WIDTH'(1) : '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] c0_reg;
            logic [DATA_WIDTH-1:0] c1_reg;
            logic [DATA_WIDTH-1:0] c2_reg;

            // Loading the first pixel into c1 and c2 makes it its own W neighbour
            // once it reaches the centre; holding c2 after the line does the same for E.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c0_reg <= '0;
                    c1_reg <= '0;
                    c2_reg <= '0;
                end else if (line_start) begin
                    c1_reg <= row_data[gi];
                    c2_reg <= row_data[gi];
                end else if (de) begin
                    c0_reg <= c1_reg;
                    c1_reg <= c2_reg;
                    c2_reg <= row_data[gi];
                end else if (line_end) begin
                    c0_reg <= c1_reg;
                    c1_reg <= c2_reg;
                end
            end

            assign win[gi][0] = c0_reg;
            assign win[gi][1] = c1_reg;
            assign win[gi][2] = c2_reg;
        end
    endgenerate

    assign valid   = de_d2_reg;
    assign col_odd = hcount_reg[0];

endmodule

// File: rtl/bayer_demosaic3x3.sv
// Bilinear 3x3 Bayer demosaic: window, then partial sums, then per-site selection.
module bayer_demosaic3x3
    import bayer_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int HEIGHT_WIDTH = 10,
    parameter int LINE_WIDTH   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync_i,
    input  logic                  de_i,
    input  logic [1:0]            pattern_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    output logic                  de_o,
    output logic [DATA_WIDTH-1:0] r_o,
    output logic [DATA_WIDTH-1:0] g_o,
    output logic [DATA_WIDTH-1:0] b_o
);

    localparam int SW = DATA_WIDTH + 2;

    logic                    frame_seen_reg;
    logic                    de_prev_reg;
    logic                    row_par_reg;
    pattern_e                pattern_reg;
    logic [HEIGHT_WIDTH-1:0] vcount_reg;
    logic                    de_acc;

    logic [2:0][2:0][DATA_WIDTH-1:0] win;
    logic                            win_valid;
    logic                            col_odd;

    // A pixel counts only inside a frame, and never in a vsync cycle.
    assign de_acc = de_i & ~vsync_i & frame_seen_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_seen_reg <= 1'b0;
            de_prev_reg    <= 1'b0;
            row_par_reg    <= 1'b0;
            pattern_reg    <= PAT_RGGB;
            vcount_reg     <= '0;
        end else begin
            de_prev_reg <= de_acc;
            if (vsync_i) begin
                frame_seen_reg <= 1'b1;
                pattern_reg    <= pattern_e'(pattern_i);
                vcount_reg     <= '0;
            end else if (de_prev_reg && !de_acc) begin
                vcount_reg <= vcount_reg + HEIGHT_WIDTH'(1);
            end
            // vcount moves on at line end, before the last centre pixel is decoded,
            // so the row parity is captured once at line start.
            if (de_acc && !de_prev_reg) begin
                row_par_reg <= vcount_reg[0];
            end
        end
    end

    bayer_window3x3 #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .de      (de_acc),
        .data0   (data0_i),
        .data1   (data1_i),
        .data2   (data2_i),
        .win     (win),
        .valid   (win_valid),
        .col_odd (col_odd)
    );

    logic [DATA_WIDTH-1:0] px_nw, px_n, px_ne, px_w, px_c, px_e, px_sw, px_s, px_se;
    assign px_nw = win[0][0];
    assign px_n  = win[0][1];
    assign px_ne = win[0][2];
    assign px_w  = win[1][0];
    assign px_c  = win[1][1];
    assign px_e  = win[1][2];
    assign px_sw = win[2][0];
    assign px_s  = win[2][1];
    assign px_se = win[2][2];

    logic [SW-1:0] cross_sum, diag_sum, horiz_sum, vert_sum;
    assign cross_sum = SW'(px_n) + SW'(px_s) + SW'(px_e) + SW'(px_w);
    assign diag_sum  = SW'(px_nw) + SW'(px_ne) + SW'(px_sw) + SW'(px_se);
    assign horiz_sum = SW'(px_e) + SW'(px_w);
    assign vert_sum  = SW'(px_n) + SW'(px_s);

    logic                  valid1_reg;
    site_e                 site_reg;
    logic [DATA_WIDTH-1:0] centre_reg;
    logic [SW-1:0]         cross_reg, diag_reg, horiz_reg, vert_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_reg <= 1'b0;
            site_reg   <= SITE_R;
            centre_reg <= '0;
            cross_reg  <= '0;
            diag_reg   <= '0;
            horiz_reg  <= '0;
            vert_reg   <= '0;
        end else begin
            valid1_reg <= win_valid;
            if (win_valid) begin
                site_reg   <= site_decode(pattern_reg, col_odd, row_par_reg);
                centre_reg <= px_c;
                cross_reg  <= cross_sum;
                diag_reg   <= diag_sum;
                horiz_reg  <= horiz_sum;
                vert_reg   <= vert_sum;
            end
        end
    end

    logic [DATA_WIDTH-1:0] cross_avg, diag_avg, horiz_avg, vert_avg;
    assign cross_avg = DATA_WIDTH'(cross_reg >> 2);
    assign diag_avg  = DATA_WIDTH'(diag_reg >> 2);
    assign horiz_avg = DATA_WIDTH'(horiz_reg >> 1);
    assign vert_avg  = DATA_WIDTH'(vert_reg >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_o <= 1'b0;
            r_o  <= '0;
            g_o  <= '0;
            b_o  <= '0;
        end else begin
            de_o <= valid1_reg;
            if (valid1_reg) begin
                unique case (site_reg)
                    SITE_R: begin
                        r_o <= centre_reg;
                        g_o <= cross_avg;
                        b_o <= diag_avg;
                    end
                    SITE_B: begin
                        r_o <= diag_avg;
                        g_o <= cross_avg;
                        b_o <= centre_reg;
                    end
                    SITE_GR: begin
                        r_o <= horiz_avg;
                        g_o <= centre_reg;
                        b_o <= vert_avg;
                    end
                    SITE_GB: begin
                        r_o <= vert_avg;
                        g_o <= centre_reg;
                        b_o <= horiz_avg;
                    end
                    default: begin
                        r_o <= centre_reg;
                        g_o <= centre_reg;
                        b_o <= centre_reg;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bayer_demosaic3x3.sv
// Directed bench for bayer_demosaic3x3: hand-computed pixels, a reference model
// for the CFA sweep, latency and per-line de_o count checks.
module tb_bayer_demosaic3x3;

    localparam int DW  = 10;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync_i;
    logic          de_i;
    logic [1:0]    pattern_i;
    logic [DW-1:0] data0_i, data1_i, data2_i;
    logic          de_o;
    logic [DW-1:0] r_o, g_o, b_o;

    bayer_demosaic3x3 dut (
        .clk       (clk),
        .rst       (rst),
        .vsync_i   (vsync_i),
        .de_i      (de_i),
        .pattern_i (pattern_i),
        .data0_i   (data0_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .de_o      (de_o),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int r;
        int g;
        int b;
    } px_t;

    px_t got_q[$];
    px_t exp_q[$];
    int  img0[16], img1[16], img2[16];
    int  er[16], eg[16], eb[16];
    int  lat_pat;
    int  line_idx;
    int  tests = 0;
    int  fails = 0;

    always @(negedge clk) begin
        if (de_o) got_q.push_back('{cyc, int'(r_o), int'(g_o), int'(b_o)});
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int site_of(input int pat, input int v, input int h);
        case (pat)
            0: return (v == 0) ? ((h == 0) ? 0 : 1) : ((h == 0) ? 2 : 3);
            1: return (v == 0) ? ((h == 0) ? 3 : 2) : ((h == 0) ? 1 : 0);
            2: return (v == 0) ? ((h == 0) ? 1 : 0) : ((h == 0) ? 3 : 2);
            default: return (v == 0) ? ((h == 0) ? 2 : 3) : ((h == 0) ? 0 : 1);
        endcase
    endfunction

    // Site codes: 0 R, 1 G in R row, 2 G in B row, 3 B.
    task automatic model_line(input int n, input int vpar);
        for (int c = 0; c < n; c++) begin
            int w, e, cn, nn, ss, ww, ee, crs, dia, hz, vt;
            w   = (c == 0) ? c : c - 1;
            e   = (c == n - 1) ? c : c + 1;
            cn  = img1[c];
            nn  = img0[c];
            ss  = img2[c];
            ww  = img1[w];
            ee  = img1[e];
            crs = (nn + ss + ee + ww) / 4;
            dia = (img0[w] + img0[e] + img2[w] + img2[e]) / 4;
            hz  = (ee + ww) / 2;
            vt  = (nn + ss) / 2;
            case (site_of(lat_pat, vpar, c & 1))
                0: begin er[c] = cn;  eg[c] = crs; eb[c] = dia; end
                3: begin er[c] = dia; eg[c] = crs; eb[c] = cn;  end
                1: begin er[c] = hz;  eg[c] = cn;  eb[c] = vt;  end
                default: begin er[c] = vt; eg[c] = cn; eb[c] = hz; end
            endcase
        end
    endtask

    task automatic set_exp(input int c, input int r, input int g, input int b);
        er[c] = r;
        eg[c] = g;
        eb[c] = b;
    endtask

    task automatic fill_flat(input int v);
        for (int c = 0; c < 16; c++) begin
            img0[c] = v; img1[c] = v; img2[c] = v;
            set_exp(c, v, v, v);
        end
    endtask

    // RGGB test card: R=0x100, G=0x200, B=0x300; line L uses rows L-1, L, L+1.
    function automatic int cfa_val(input int row, input int col);
        if ((row & 1) == 0) return ((col & 1) == 0) ? 'h100 : 'h200;
        return ((col & 1) == 0) ? 'h200 : 'h300;
    endfunction

    task automatic fill_cfa(input int line);
        for (int c = 0; c < 16; c++) begin
            img0[c] = cfa_val(line + 1, c);
            img1[c] = cfa_val(line, c);
            img2[c] = cfa_val(line + 1, c);
        end
    endtask

    task automatic send_line(input int n, input bit live);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            de_i    = 1'b1;
            data0_i = DW'(img0[c]);
            data1_i = DW'(img1[c]);
            data2_i = DW'(img2[c]);
            if (live) exp_q.push_back('{cyc + LAT, er[c], eg[c], eb[c]});
        end
        @(negedge clk);
        de_i = 1'b0;
        repeat (3) @(negedge clk);
        if (live) line_idx++;
    endtask

    task automatic do_vsync(input int p);
        @(negedge clk);
        vsync_i   = 1'b1;
        de_i      = 1'b0;
        pattern_i = 2'(p);
        @(negedge clk);
        vsync_i  = 1'b0;
        lat_pat  = p;
        line_idx = 0;
    endtask

    task automatic compare(input string tag);
        px_t g, e;
        int  i;
        repeat (8) @(negedge clk);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        i = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("[TB] %s px%0d rgb=%03h %03h %03h exp=%03h %03h %03h @%0d",
                     tag, i, g.r, g.g, g.b, e.r, e.g, e.b, g.cyc);
            check($sformatf("%s.px%0d.lat", tag, i), g.cyc, e.cyc);
            check($sformatf("%s.px%0d.r", tag, i), g.r, e.r);
            check($sformatf("%s.px%0d.g", tag, i), g.g, e.g);
            check($sformatf("%s.px%0d.b", tag, i), g.b, e.b);
            i++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; vsync_i = 1'b0; de_i = 1'b0; pattern_i = 2'd0;
        data0_i = '0; data1_i = '0; data2_i = '0;
        lat_pat = 0; line_idx = 0;
        repeat (2) @(negedge clk);
        check("reset.de_o", int'(de_o), 0);
        check("reset.r", int'(r_o), 0);
        check("reset.g", int'(g_o), 0);
        check("reset.b", int'(b_o), 0);
        rst = 1'b0;

        // No vsync yet: a line must be ignored.
        fill_flat('h200);
        send_line(8, 1'b0);
        compare("prevsync");

        // Flat field.
        do_vsync(0);
        fill_flat('h200);
        send_line(8, 1'b1);
        send_line(8, 1'b1);
        compare("flat");

        // RGGB test card, hand-computed including clamped edges.
        do_vsync(0);
        fill_cfa(0);
        for (int c = 1; c < 7; c++) set_exp(c, 'h100, 'h200, 'h300);
        set_exp(0, 'h100, 'h1C0, 'h280);
        set_exp(7, 'h180, 'h200, 'h300);
        send_line(8, 1'b1);
        fill_cfa(1);
        for (int c = 1; c < 7; c++) set_exp(c, 'h100, 'h200, 'h300);
        set_exp(0, 'h100, 'h200, 'h280);
        set_exp(7, 'h180, 'h240, 'h300);
        send_line(8, 1'b1);
        compare("cfa");

        // CFA order sweep; pattern_i is changed mid-frame and must be ignored.
        for (int c = 0; c < 8; c++) begin
            img0[c] = (c * 53 + 17) & 'h3FF;
            img1[c] = (c * 97 + 301) & 'h3FF;
            img2[c] = (c * 211 + 640) & 'h3FF;
        end
        for (int p = 0; p < 4; p++) begin
            do_vsync(p);
            pattern_i = 2'((p + 1) % 4);
            for (int l = 0; l < 2; l++) begin
                model_line(8, line_idx & 1);
                send_line(8, 1'b1);
            end
            compare($sformatf("pat%0d", p));
        end

        // Edge clamp and saturation headroom on a 4-pixel line.
        do_vsync(0);
        for (int c = 0; c < 4; c++) begin
            img0[c] = 'h3FF; img2[c] = 'h3FF;
        end
        img1[0] = 'h100; img1[1] = 'h200; img1[2] = 'h300; img1[3] = 'h3FF;
        set_exp(0, 'h100, 'h2BF, 'h3FF);
        set_exp(1, 'h200, 'h200, 'h3FF);
        set_exp(2, 'h300, 'h37F, 'h3FF);
        set_exp(3, 'h37F, 'h3FF, 'h3FF);
        send_line(4, 1'b1);
        fill_flat('h3FF);
        send_line(4, 1'b1);
        compare("edge");

        // vsync colliding with de: the pixel is dropped.
        @(negedge clk);
        vsync_i = 1'b1; de_i = 1'b1; pattern_i = 2'd0;
        data0_i = 'h123; data1_i = 'h123; data2_i = 'h123;
        @(negedge clk);
        vsync_i = 1'b0; de_i = 1'b0;
        lat_pat = 0; line_idx = 0;
        compare("collide");

        // One good line, then a reset three pixels into the next one.
        fill_flat('h155);
        send_line(8, 1'b1);
        compare("prereset");
        fill_cfa(0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            de_i = 1'b1;
            data0_i = DW'(img0[c]); data1_i = DW'(img1[c]); data2_i = DW'(img2[c]);
        end
        @(negedge clk);
        rst = 1'b1;
        de_i = 1'b0;
        #1;
        check("midrst.de_o", int'(de_o), 0);
        check("midrst.r", int'(r_o), 0);
        check("midrst.g", int'(g_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 3; c < 8; c++) begin
            @(negedge clk);
            de_i = 1'b1;
        end
        @(negedge clk);
        de_i = 1'b0;
        repeat (2) @(negedge clk);
        send_line(8, 1'b0);
        compare("postrst");

        // Resume after vsync: line 0 must decode as an R row again.
        do_vsync(0);
        fill_cfa(0);
        for (int c = 1; c < 7; c++) set_exp(c, 'h100, 'h200, 'h300);
        set_exp(0, 'h100, 'h1C0, 'h280);
        set_exp(7, 'h180, 'h200, 'h300);
        send_line(8, 1'b1);
        compare("resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bayer_demosaic3x3.md
BAYER_DEMOSAIC3X3 -- requirements
Module: bayer_demosaic3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: bit width of raw and per-channel output samples.
REQ-002 SHALL have parameter HEIGHT_WIDTH, default 10: width of the internal line counter.
REQ-003 SHALL have parameter LINE_WIDTH, default 11: width of the internal pixel (column) counter.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port vsync_i  input  1: frame start; high for one or more cycles between frames.
REQ-007 SHALL have port de_i  input  1: pixel valid; high for one full line, low for at least 1 cycle between lines.
REQ-008 SHALL have port pattern_i  input  2: CFA order, 0 RGGB, 1 BGGR, 2 GRBG, 3 GBRG, sampled only while vsync_i is high.
REQ-009 SHALL have ports data0_i, data1_i, data2_i  input  DATA_WIDTH each: same column from the line above, the centre line and the line below.
REQ-010 SHALL have port de_o  output  1: output pixel valid.
REQ-011 SHALL have ports r_o, g_o, b_o  output  DATA_WIDTH each: interpolated RGB for the centre pixel.

Function
REQ-012 SHALL keep a 3-column window (c0 oldest, c1 centre, c2 newest) of 3 rows each.
REQ-013 Window update: first pixel of a line (de_i=1, previous de_i=0) loads it into c1 and c2; every later de_i=1 cycle shifts c0<=c1, c1<=c2, c2<=input; the first de_i=0 cycle after a line shifts with c2 held, which replicates the last column; all other cycles hold.
REQ-014 Horizontal edges SHALL clamp: pixel 0 uses itself as its W neighbour, and the last pixel uses itself as its E neighbour. No vertical clamping is done; the rows are used as supplied.
REQ-015 Latency SHALL be fixed: the pixel presented with de_i at cycle t appears on r_o/g_o/b_o with de_o=1 at cycle t+4.
REQ-016 de_o SHALL be high for exactly as many cycles per line as de_i, in the same order.
REQ-017 SHALL maintain hcount (centre column index, 0 at each line start) and vcount (cleared by vsync_i, incremented on each de_i falling edge).
REQ-018 Site colour SHALL come from {hcount[0], vcount[0]} and the latched pattern. For RGGB: (0,0)=R, (1,0)=G in an R row, (0,1)=G in a B row, (1,1)=B. The other patterns follow by CFA definition.
REQ-019 At an R site: r=C, g=(N+S+E+W)>>2, b=(NE+NW+SE+SW)>>2. A B site SHALL be handled symmetrically.
REQ-020 At a G site in an R row: g=C, r=(E+W)>>1, b=(N+S)>>1. A G site in a B row SHALL swap r and b.
REQ-021 Sums SHALL use DATA_WIDTH+2 bits with floor truncation, and outputs SHALL never overflow.
REQ-022 If vsync_i and de_i are high in the same cycle, vsync_i SHALL win: counters clear and the pixel is ignored.
REQ-023 When de_o=0, r_o/g_o/b_o SHALL hold their last value.
REQ-024 The pipeline SHALL be two registered stages after the window: stage 1 registers the partial sums and site code, stage 2 registers the selected and shifted outputs.

Reset
REQ-025 rst=1 SHALL immediately force de_o=0, r_o=g_o=b_o=0, counters=0, window=0 and latched pattern=RGGB.
REQ-026 After reset release, de_o SHALL stay 0 until the first vsync_i has been seen; de_i before that SHALL be ignored.
REQ-027 A reset mid-line SHALL discard all in-flight pixels, with no partial line emitted.

Structure
REQ-028 A shared package bayer_pkg SHALL hold the pattern enum (RGGB/BGGR/GRBG/GBRG), the site enum (R, GR, GB, B) and localparam LATENCY=4.
REQ-029 Window and edge clamping SHALL live in one sub-module, bayer_window3x3; site decode and arithmetic SHALL stay in the top level.

Verification
REQ-030 Flat field, all inputs 0x200, RGGB, 8-pixel lines -> r=g=b=0x200 on every pixel, with de_o 8 cycles per line delayed by 4.
REQ-031 RGGB, R sites=0x100, G=0x200, B=0x300 -> R site gives (0x100,0x200,0x300); G sites and B site give the same triple.
REQ-032 Pattern sweep 0..3 with identical raw data -> outputs match the golden model for each CFA order; changing pattern_i mid-frame has no effect.
REQ-033 Left/right edge, line of 4 with E=0x3FF ramp -> pixel 0 and pixel 3 use the clamped neighbours; sums with 0x3FF inputs give 0x3FF, no wrap.
REQ-034 vsync_i and de_i high together, then assert rst mid-line -> no de_o from the collided pixel; after rst, de_o stays 0 until the next vsync_i, then resumes with vcount=0.
